// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port 0 is the CPU, port 1 is the auxiliary master (loader / display reader).
package mem_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arbState_e;

  function automatic logic [1:0] portOneHot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled as one interface.
// The arbiter uses the slave view; the surrounding system (or bench) uses master.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic [1:0]        req;
  logic [1:0]        we;
  logic [1:0]        lock;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_oe;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req, we, lock, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt, done, rdata, busy, mem_cs, mem_we, mem_addr, mem_wdata, mem_oe
  );

  modport master (
    output req, we, lock, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt, done, rdata, busy, mem_cs, mem_we, mem_addr, mem_wdata, mem_oe
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way winner select: a valid lock keeps the current owner
// until the lock limit is hit with the other port waiting, else round-robin.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       lastOwner_i,
  input  logic       lockValid_i,
  input  logic       owner_i,
  input  logic       lockHit_i,
  output logic       valid_o,
  output logic       winner_o
);

  logic lockWin;

  always_comb begin
    valid_o  = |req_i;
    winner_o = PORT_CPU;
    lockWin  = lockValid_i && req_i[owner_i] && (!lockHit_i || !req_i[!owner_i]);
    if (lockWin) begin
      winner_o = owner_i;
    end else if (req_i[!lastOwner_i]) begin
      winner_o = !lastOwner_i;
    end else if (req_i[lastOwner_i]) begin
      winner_o = lastOwner_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one 128x32 memory, one access per cycle with
// round-robin fairness and a bounded lock for back-to-back bursts.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arbState_e         state_q, state_d;
  logic              owner_q, owner_d;
  logic              lastOwner_q, lastOwner_d;
  logic              lockValid_q, lockValid_d;
  logic [CNT_W-1:0]  lockCnt_q, lockCnt_d;
  logic [ADDR_W-1:0] cmdAddr_q, cmdAddr_d;
  logic              cmdWe_q, cmdWe_d;
  logic [DATA_W-1:0] cmdWdata_q, cmdWdata_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic grantValid;
  logic winner;
  logic lockHit;
  logic inAccess;

  assign lockHit  = (lockCnt_q >= CNT_W'(MAX_LOCK));
  assign inAccess = (state_q == ACCESS);

  rr_pick2 uPick (
    .req_i       (bus.req),
    .lastOwner_i (lastOwner_q),
    .lockValid_i (lockValid_q),
    .owner_i     (owner_q),
    .lockHit_i   (lockHit),
    .valid_o     (grantValid),
    .winner_o    (winner)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req)  state_d = ACCESS;
      ACCESS:  if (!(|bus.req)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion of the access in flight, then capture of the newly granted command.
  always_comb begin
    owner_d     = owner_q;
    lastOwner_d = lastOwner_q;
    lockValid_d = lockValid_q;
    lockCnt_d   = lockCnt_q;
    cmdAddr_d   = cmdAddr_q;
    cmdWe_d     = cmdWe_q;
    cmdWdata_d  = cmdWdata_q;
    done_d      = 2'b00;
    rdata_d     = rdata_q;

    if (inAccess) begin
      done_d = portOneHot(owner_q);
      if (!cmdWe_q) begin
        rdata_d = bus.mem_rdata;
      end
    end

    if (grantValid) begin
      owner_d     = winner;
      lastOwner_d = winner;
      lockValid_d = bus.lock[winner];
      cmdWe_d     = bus.we[winner];
      cmdAddr_d   = winner ? bus.addr1 : bus.addr0;
      cmdWdata_d  = winner ? bus.wdata1 : bus.wdata0;
      if (lockValid_q && (winner == owner_q)) begin
        if (lockCnt_q < CNT_W'(MAX_LOCK)) begin
          lockCnt_d = lockCnt_q + CNT_W'(1);
        end
      end else begin
        lockCnt_d = CNT_W'(1);
      end
    end
  end

  // Reset value of lastOwner makes the CPU win the first tie.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      owner_q     <= PORT_CPU;
      lastOwner_q <= PORT_AUX;
      lockValid_q <= 1'b0;
      lockCnt_q   <= '0;
      cmdAddr_q   <= '0;
      cmdWe_q     <= 1'b0;
      cmdWdata_q  <= '0;
      done_q      <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastOwner_q <= lastOwner_d;
      lockValid_q <= lockValid_d;
      lockCnt_q   <= lockCnt_d;
      cmdAddr_q   <= cmdAddr_d;
      cmdWe_q     <= cmdWe_d;
      cmdWdata_q  <= cmdWdata_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.gnt       = (RST && grantValid) ? portOneHot(winner) : 2'b00;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = inAccess;
  assign bus.mem_cs    = inAccess;
  assign bus.mem_we    = inAccess & cmdWe_q;
  assign bus.mem_oe    = inAccess & cmdWe_q;
  assign bus.mem_addr  = inAccess ? cmdAddr_q : '0;
  assign bus.mem_wdata = inAccess ? cmdWdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a reference model predicts grants and memory
// traffic each cycle and queues expected completions for a separate monitor.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int MAX_LOCK = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Memory samples on the falling edge; bus is driven by the arbiter only when writing.
  logic [DATA_W-1:0] tbMem [128];
  logic [DATA_W-1:0] readLatch = '0;
  logic              memLoaded = 1'b0;

  always @(negedge CLK) begin
    if (!memLoaded) begin
      for (int i = 0; i < 128; i++) tbMem[i] <= DATA_W'(32'hA0 + i);
      memLoaded <= 1'b1;
    end else if (bus.mem_cs) begin
      if (bus.mem_we) tbMem[bus.mem_addr] <= bus.mem_wdata;
      else            readLatch <= tbMem[bus.mem_addr];
    end
  end

  assign bus.mem_rdata = bus.mem_oe ? bus.mem_wdata : readLatch;

  typedef struct {
    int                due;
    logic              port;
    logic [DATA_W-1:0] rdata;
  } doneExp_t;

  doneExp_t sbQ[$];
  doneExp_t monE;
  int checks   = 0;
  int errors   = 0;
  int cycleCnt = 0;

  // Reference model state
  logic [DATA_W-1:0] shadow [128];
  logic              mLast;
  logic              mOwner;
  logic              mLockActive;
  int                mRun;
  logic [DATA_W-1:0] mLastRead;
  logic              mInFlight;
  logic              fWe;
  logic [ADDR_W-1:0] fAddr;
  logic [DATA_W-1:0] fData;

  logic              lastValid;
  logic              lastWin;
  logic [1:0]        lastDutGnt;

  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  task automatic resetModel();
    mLast       = PORT_AUX;
    mOwner      = PORT_CPU;
    mLockActive = 1'b0;
    mRun        = 0;
    mLastRead   = '0;
    mInFlight   = 1'b0;
    fWe         = 1'b0;
    fAddr       = '0;
    fData       = '0;
  endtask

  // Called just after a rising edge: drive one cycle of requests, check at the
  // falling edge, advance the model, and return just after the next rising edge.
  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                               input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                               input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    logic              win;
    logic              expValid;
    logic              cWe;
    logic [ADDR_W-1:0] cAddr;
    logic [DATA_W-1:0] cData;
    logic              expCs;
    logic              expWe;

    bus.req = r; bus.we = w; bus.lock = l;
    bus.addr0 = a0; bus.addr1 = a1; bus.wdata0 = d0; bus.wdata1 = d1;

    expValid = (r != 2'b00);
    if (mLockActive && r[mOwner] && (mRun < MAX_LOCK || !r[!mOwner])) win = mOwner;
    else if (r[!mLast]) win = !mLast;
    else win = mLast;

    @(negedge CLK);
    expCs = mInFlight;
    expWe = mInFlight && fWe;
    checkOutput("gnt", 32'(bus.gnt), expValid ? 32'(portOneHot(win)) : 32'h0);
    checkOutput("busy", 32'(bus.busy), 32'(expCs));
    checkOutput("mem_cs", 32'(bus.mem_cs), 32'(expCs));
    checkOutput("mem_we", 32'(bus.mem_we), 32'(expWe));
    checkOutput("mem_oe", 32'(bus.mem_oe), 32'(expWe));
    checkOutput("mem_addr", 32'(bus.mem_addr), expCs ? 32'(fAddr) : 32'h0);
    checkOutput("mem_wdata", 32'(bus.mem_wdata), expCs ? fData : 32'h0);
    lastDutGnt = bus.gnt;

    if (expValid) begin
      if (mLockActive && win == mOwner) mRun = mRun + 1;
      else mRun = 1;
      mLockActive = l[win];
      mOwner      = win;
      mLast       = win;
      cWe   = w[win];
      cAddr = win ? a1 : a0;
      cData = win ? d1 : d0;
      if (cWe) shadow[cAddr] = cData;
      else     mLastRead = shadow[cAddr];
      sbQ.push_back('{due: cycleCnt + 2, port: win, rdata: mLastRead});
      fWe = cWe; fAddr = cAddr; fData = cData;
    end
    mInFlight = expValid;
    lastValid = expValid;
    lastWin   = win;

    @(posedge CLK);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  // Completion monitor, decoupled from the stimulus process.
  always @(negedge CLK) begin
    if (RST) begin
      if (bus.done != 2'b00) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_done", 32'(bus.done), 32'h0);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("done_port", 32'(bus.done), 32'(portOneHot(monE.port)));
          checkOutput("done_cycle", 32'(cycleCnt), 32'(monE.due));
          checkOutput("rdata", bus.rdata, monE.rdata);
        end
      end
      while (sbQ.size() > 0 && sbQ[0].due < cycleCnt) begin
        checks++;
        errors++;
        $display("[TB] FAIL done_missing: got no done, expected port %0d at cycle %0d", sbQ[0].port, sbQ[0].due);
        void'(sbQ.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]        pend;
    logic [1:0]        pw;
    logic [1:0]        pl;
    logic [ADDR_W-1:0] pa [2];
    logic [DATA_W-1:0] pd [2];
    int                burst;
    logic              gnt0Seen;
    logic [DATA_W-1:0] savedWord;

    for (int i = 0; i < 128; i++) shadow[i] = DATA_W'(32'hA0 + i);
    resetModel();
    bus.req = 2'b11; bus.we = 2'b00; bus.lock = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

    // Reset state, with requests present to show gnt is forced low
    repeat (3) @(negedge CLK);
    checkOutput("rst_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("rst_done", 32'(bus.done), 32'h0);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_mem_cs", 32'(bus.mem_cs), 32'h0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'h0);
    checkOutput("rst_mem_oe", 32'(bus.mem_oe), 32'h0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    bus.req = 2'b00;
    @(posedge CLK);
    #1;
    RST = 1'b1;

    $display("[TB] single read of address 5");
    applyStimulus(2'b01, 2'b00, 2'b00, 7'd5, 7'd0, '0, '0);
    idleCycle();

    $display("[TB] both ports reading back to back");
    repeat (8) applyStimulus(2'b11, 2'b00, 2'b00, 7'd1, 7'd2, '0, '0);
    idleCycle();

    $display("[TB] port 1 writes address 127, port 0 reads it back");
    applyStimulus(2'b10, 2'b10, 2'b00, 7'd0, 7'd127, '0, 32'hDEAD_BEEF);
    applyStimulus(2'b01, 2'b00, 2'b00, 7'd127, 7'd0, '0, '0);
    idleCycle();
    idleCycle();

    $display("[TB] locked burst on port 1 against waiting port 0");
    applyStimulus(2'b10, 2'b00, 2'b10, 7'd4, 7'd3, '0, '0);
    burst = (lastDutGnt == 2'b10) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'b11, 2'b00, 2'b10, 7'd4, 7'd3, '0, '0);
      if (lastDutGnt == 2'b10) burst++;
      else break;
    end
    checkOutput("lock_burst_len", 32'(burst), 32'(MAX_LOCK));
    idleCycle();
    idleCycle();

    $display("[TB] port 0 request withdrawn while port 1 wins");
    applyStimulus(2'b01, 2'b00, 2'b00, 7'd6, 7'd0, '0, '0);
    applyStimulus(2'b11, 2'b00, 2'b00, 7'd9, 7'd8, '0, '0);
    gnt0Seen = lastDutGnt[0];
    applyStimulus(2'b00, 2'b00, 2'b00, 7'd9, 7'd8, '0, '0);
    gnt0Seen = gnt0Seen | lastDutGnt[0];
    checkOutput("withdrawn_gnt0", 32'(gnt0Seen), 32'h0);
    idleCycle();
    idleCycle();

    $display("[TB] reset during a write access");
    savedWord = shadow[10];
    applyStimulus(2'b10, 2'b10, 2'b00, 7'd0, 7'd10, '0, 32'h1234_5678);
    RST = 1'b0;
    bus.req = 2'b00;
    #1;
    checkOutput("midrst_mem_cs", 32'(bus.mem_cs), 32'h0);
    checkOutput("midrst_mem_we", 32'(bus.mem_we), 32'h0);
    checkOutput("midrst_mem_oe", 32'(bus.mem_oe), 32'h0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'h0);
    checkOutput("midrst_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("midrst_rdata", bus.rdata, 32'h0);
    void'(sbQ.pop_back());
    shadow[10] = savedWord;
    resetModel();
    @(negedge CLK);
    @(posedge CLK);
    #1;
    checkOutput("midrst_mem_word", tbMem[10], savedWord);
    checkOutput("midrst_done", 32'(bus.done), 32'h0);
    RST = 1'b1;
    applyStimulus(2'b01, 2'b00, 2'b00, 7'd10, 7'd0, '0, '0);
    idleCycle();

    $display("[TB] randomized traffic");
    pend = 2'b00; pw = 2'b00; pl = 2'b00;
    pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(9) < 6) begin
            pend[p] = 1'b1;
            pw[p]   = 1'($urandom_range(1));
            pl[p]   = ($urandom_range(3) == 0);
            pa[p]   = ($urandom_range(3) == 0) ? 7'd127 : ADDR_W'($urandom_range(15));
            pd[p]   = $urandom;
          end
        end else if ($urandom_range(19) == 0) begin
          pend[p] = 1'b0;
        end
      end
      applyStimulus(pend, pw, pend & pl, pa[0], pa[1], pd[0], pd[1]);
      if (lastValid) pend[lastWin] = 1'b0;
    end

    repeat (3) idleCycle();
    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
